control_unit: RTL and testbench

Multi-cycle instruction sequencer directly upstream of the CPU datapath. It fetches 25-bit instruction words from a synchronous instruction memory and decodes them. For each instruction it drives the datapath's one-hot register-enable and bus tri-state vectors, plus the code word carrying the ALU operation and immediate, step by step until the instruction completes. It also owns the 6-bit program counter presented on `address`.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/ctrl_decode.sv | 59 +++++
 rtl/control_unit.sv | 71 +++++++
 tb/tb_control_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit, its decoder and the ALU:
// opcodes, ALU operation codes, sequencer states and instruction fields.
package cpu_pkg;

  localparam int OH_W = 20;

  localparam int OP_HI  = 24;
  localparam int OP_LO  = 22;
  localparam int RX_HI  = 21;
  localparam int RX_LO  = 19;
  localparam int RY_HI  = 18;
  localparam int RY_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam int IDX_G   = 9;
  localparam int IDX_A   = 10;
  localparam int IDX_IMM = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    T1,
    T2,
    T3,
    HALT
  } state_t;

  function automatic logic [2:0] alu_op_of(input logic [2:0] opcode);
    case (opcode)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

  // MV and MVI finish in T1; every other non-HALT opcode runs T1..T3.
  function automatic logic is_move(input logic [2:0] opcode);
    return (opcode == OP_MV) || (opcode == OP_MVI);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational step decoder: turns the sequencer state and the held
// instruction into register enables, bus driver selects and the ALU code word.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  state_t             state,
  input  logic [IMM_W+8:0]   ir,
  output logic [OH_W-1:0]    r_en_OH,
  output logic [OH_W-1:0]    tri_controller_OH,
  output logic [IMM_W+6:0]   code
);

  logic [2:0]       opcode;
  logic [2:0]       rx;
  logic [2:0]       ry;
  logic [IMM_W-1:0] imm;
  logic [2:0]       alu_op;

  assign opcode = ir[OP_HI:OP_LO];
  assign rx     = ir[RX_HI:RX_LO];
  assign ry     = ir[RY_HI:RY_LO];
  assign imm    = ir[IMM_W-1:0];

  // ALU instructions: A <- Rx in T1, G <- A op Ry in T2, Rx <- G in T3.
  always_comb begin
    r_en_OH           = '0;
    tri_controller_OH = '0;
    alu_op            = ALU_ADD;
    unique case (state)
      T1: begin
        if (opcode == OP_MV) begin
          tri_controller_OH[ry] = 1'b1;
          r_en_OH[rx]           = 1'b1;
        end else if (opcode == OP_MVI) begin
          tri_controller_OH[IDX_IMM] = 1'b1;
          r_en_OH[rx]                = 1'b1;
        end else begin
          tri_controller_OH[rx] = 1'b1;
          r_en_OH[IDX_A]        = 1'b1;
        end
      end
      T2: begin
        tri_controller_OH[ry] = 1'b1;
        r_en_OH[IDX_G]        = 1'b1;
        alu_op                = alu_op_of(opcode);
      end
      T3: begin
        tri_controller_OH[IDX_G] = 1'b1;
        r_en_OH[rx]              = 1'b1;
      end
      default: ;
    endcase
  end

  assign code = {alu_op, 4'b0000, imm};

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: owns PC and IR, steps each instruction
// through FETCH/LOAD/T1..T3 and drives the datapath through ctrl_decode.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W  = 6,
  parameter int IMM_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [IMM_W+8:0]   instr,
  output logic [PC_W-1:0]    address,
  output logic [OH_W-1:0]    r_en_OH,
  output logic [OH_W-1:0]    tri_controller_OH,
  output logic [IMM_W+6:0]   code,
  output logic               busy,
  output logic               done,
  output logic               halted
);

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [IMM_W+8:0] ir;
  logic [2:0]       opcode;

  assign opcode = ir[OP_HI:OP_LO];

  // rst_n is active-high despite its name. HALT is absorbing until reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      unique case (state)
        IDLE:  if (run) state <= FETCH;
        FETCH: state <= LOAD;
        LOAD: begin
          ir    <= instr;
          pc    <= pc + PC_W'(1);
          state <= (instr[OP_HI:OP_LO] == OP_HALT) ? HALT : T1;
        end
        T1: begin
          if (is_move(opcode)) state <= run ? FETCH : IDLE;
          else                 state <= T2;
        end
        T2:    state <= T3;
        T3:    state <= run ? FETCH : IDLE;
        HALT:  state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign address = (state == FETCH) ? pc : '0;
  assign busy    = (state != IDLE) && (state != HALT);
  assign done    = ((state == T1) && is_move(opcode)) || (state == T3);
  assign halted  = (state == HALT);

  ctrl_decode #(
    .IMM_W(IMM_W)
  ) u_decode (
    .state             (state),
    .ir                (ir),
    .r_en_OH           (r_en_OH),
    .tri_controller_OH (tri_controller_OH),
    .code              (code)
  );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: instruction memory and datapath models
// around the DUT, expected steps queued from a program-level reference model.
module tb_control_unit;

  typedef struct packed {
    logic [19:0] r_en;
    logic [19:0] drv;
    logic [22:0] code;
    logic        dn;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic [24:0] instr;
  logic [5:0]  address;
  logic [19:0] r_en_OH;
  logic [19:0] tri_controller_OH;
  logic [22:0] code;
  logic        busy;
  logic        done;
  logic        halted;

  control_unit #(
    .PC_W (6),
    .IMM_W(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run              (run),
    .instr            (instr),
    .address          (address),
    .r_en_OH          (r_en_OH),
    .tri_controller_OH(tri_controller_OH),
    .code             (code),
    .busy             (busy),
    .done             (done),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word appears the cycle after its address.
  logic [24:0] mem [64];
  always @(posedge clk) instr <= mem[address];

  // Datapath model: R0-R7, A and G loading from a one-hot driven bus.
  logic [15:0] dp_r [8];
  logic [15:0] dp_a;
  logic [15:0] dp_g;
  logic [15:0] bus;
  logic        dp_clear = 1'b1;

  function automatic logic [15:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 16'h0;
    endcase
  endfunction

  always_comb begin
    bus = 16'h0;
    for (int i = 0; i < 8; i++) if (tri_controller_OH[i]) bus = dp_r[i];
    if (tri_controller_OH[9])  bus = dp_g;
    if (tri_controller_OH[10]) bus = code[15:0];
  end

  always @(posedge clk) begin
    if (dp_clear) begin
      for (int i = 0; i < 8; i++) dp_r[i] <= 16'h0;
      dp_a <= 16'h0;
      dp_g <= 16'h0;
    end else begin
      for (int i = 0; i < 8; i++) if (r_en_OH[i]) dp_r[i] <= bus;
      if (r_en_OH[10]) dp_a <= bus;
      if (r_en_OH[9])  dp_g <= aluModel(dp_a, bus, code[22:20]);
    end
  end

  step_t       step_q [$];
  logic [5:0]  addr_q [$];
  logic [15:0] ref_r [8];
  int          checks = 0;
  int          errors = 0;
  int          fetches = 0;
  int          dones = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=absent expected=present", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [24:0] enc(input int op, input int rx, input int ry,
                                      input logic [15:0] imm);
    return {3'(op), 3'(rx), 3'(ry), imm};
  endfunction

  function automatic step_t mkStep(input int en_idx, input int drv_idx,
                                   input logic [2:0] alu, input logic [15:0] imm,
                                   input logic dn);
    step_t s;
    s.r_en          = '0;
    s.r_en[en_idx]  = 1'b1;
    s.drv           = '0;
    s.drv[drv_idx]  = 1'b1;
    s.code          = {alu, 4'b0000, imm};
    s.dn            = dn;
    return s;
  endfunction

  // Program-level reference: architectural effect plus expected bus steps.
  task automatic modelProgram(input int n);
    int          pc = 0;
    logic [24:0] w;
    int          op, rx, ry;
    logic [15:0] imm, a, b, res;
    logic [2:0]  alu;
    for (int k = 0; k < n; k++) begin
      w = mem[pc];
      addr_q.push_back(6'(pc));
      pc  = (pc + 1) % 64;
      op  = int'(w[24:22]);
      rx  = int'(w[21:19]);
      ry  = int'(w[18:16]);
      imm = w[15:0];
      if (op == 7) break;
      if (op == 0) begin
        ref_r[rx] = ref_r[ry];
        step_q.push_back(mkStep(rx, ry, 3'd0, imm, 1'b1));
      end else if (op == 1) begin
        ref_r[rx] = imm;
        step_q.push_back(mkStep(rx, 10, 3'd0, imm, 1'b1));
      end else begin
        a = ref_r[rx];
        b = ref_r[ry];
        case (op)
          2:       begin res = a + b; alu = 3'd0; end
          3:       begin res = a - b; alu = 3'd1; end
          4:       begin res = a & b; alu = 3'd2; end
          5:       begin res = a | b; alu = 3'd3; end
          default: begin res = a ^ b; alu = 3'd4; end
        endcase
        ref_r[rx] = res;
        step_q.push_back(mkStep(10, rx, 3'd0, imm, 1'b0));
        step_q.push_back(mkStep(9, ry, alu, imm, 1'b0));
        step_q.push_back(mkStep(rx, 9, 3'd0, imm, 1'b1));
      end
    end
  endtask

  // Monitor: FETCH is the first busy cycle after idle or after a done cycle.
  task automatic runMonitor();
    logic  prev_busy = 1'b0;
    logic  prev_done = 1'b0;
    logic  prev_run = 1'b0;
    step_t exp_s;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        prev_busy = 1'b0;
        prev_done = 1'b0;
        prev_run  = 1'b0;
      end else begin
        if (prev_done) checkOutput(prev_run ? "no_bubble" : "idle_after_done", 32'(busy), 32'(prev_run));
        if (busy && (!prev_busy || prev_done)) begin
          fetches++;
          if (addr_q.size() == 0) reportFail("unexpected_fetch");
          else checkOutput("fetch_addr", 32'(address), 32'(addr_q.pop_front()));
        end
        checkOutput("tri_onehot", 32'($countones(tri_controller_OH) > 1), 32'd0);
        if (r_en_OH != '0 || tri_controller_OH != '0 || done) begin
          if (done) dones++;
          if (step_q.size() == 0) reportFail("unexpected_step");
          else begin
            exp_s = step_q.pop_front();
            checkOutput("step_r_en", 32'(r_en_OH), 32'(exp_s.r_en));
            checkOutput("step_tri", 32'(tri_controller_OH), 32'(exp_s.drv));
            checkOutput("step_code", 32'(code), 32'(exp_s.code));
            checkOutput("step_done", 32'(done), 32'(exp_s.dn));
          end
        end
        prev_busy = busy;
        prev_done = done;
        prev_run  = run;
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b1;
    run   = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic clearAll();
    dp_clear = 1'b1;
    tick();
    dp_clear = 1'b0;
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0;
    step_q.delete();
    addr_q.delete();
  endtask

  task automatic waitFetches(input int target);
    int cnt = 0;
    while (fetches < target && cnt < 2000) begin
      tick();
      cnt++;
    end
    if (fetches < target) reportFail("fetch_timeout");
  endtask

  task automatic checkRegs();
    for (int i = 0; i < 8; i++) checkOutput($sformatf("R%0d", i), 32'(dp_r[i]), 32'(ref_r[i]));
    checkOutput("steps_drained", step_q.size(), 0);
    checkOutput("fetches_drained", addr_q.size(), 0);
  endtask

  // Runs n_exec instructions from PC 0; either ends in HALT or drops run
  // drop_delay cycles after the LOAD of the last instruction.
  task automatic applyStimulus(input int n_exec, input int drop_delay, input bit ends_halt);
    int f0 = fetches;
    int cnt = 0;
    modelProgram(n_exec);
    run = 1'b1;
    waitFetches(f0 + n_exec);
    if (ends_halt) begin
      checkOutput("halt_load_busy", 32'(busy), 32'd1);
      checkOutput("halt_load_halted", 32'(halted), 32'd0);
      tick();
      checkOutput("halted", 32'(halted), 32'd1);
      checkOutput("halt_busy", 32'(busy), 32'd0);
      repeat (5) tick();
      checkOutput("halt_stays", 32'(halted), 32'd1);
    end else begin
      repeat (drop_delay) tick();
      run = 1'b0;
      while ((busy || step_q.size() != 0) && cnt < 50) begin
        tick();
        cnt++;
      end
      if (busy) reportFail("finish_timeout");
      tick();
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_halted", 32'(halted), 32'd0);
    end
    checkRegs();
  endtask

  task automatic randomProgram(input int n);
    for (int i = 0; i < n; i++)
      mem[i] = enc($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7),
                   16'($urandom));
    mem[n] = enc(7, 0, 0, 16'h0);
  endtask

  initial begin
    int f0;
    int n;
    fork
      runMonitor();
    join_none

    // Reset state.
    doReset();
    clearAll();
    checkOutput("rst_address", 32'(address), 32'd0);
    checkOutput("rst_r_en", 32'(r_en_OH), 32'd0);
    checkOutput("rst_tri", 32'(tri_controller_OH), 32'd0);
    checkOutput("rst_code", 32'(code), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);

    // MVI R2,0x1234 then HALT.
    mem[0] = enc(1, 2, 0, 16'h1234);
    mem[1] = enc(7, 0, 0, 16'h0);
    applyStimulus(2, 0, 1'b1);
    checkOutput("mvi_R2", 32'(dp_r[2]), 32'h1234);
    doReset();
    checkOutput("reset_clears_halt", 32'(halted), 32'd0);

    // MVI R1,5 / MVI R2,3 / SUB R1,R2 / HALT.
    clearAll();
    mem[0] = enc(1, 1, 0, 16'd5);
    mem[1] = enc(1, 2, 0, 16'd3);
    mem[2] = enc(3, 1, 2, 16'h0);
    mem[3] = enc(7, 0, 0, 16'h0);
    applyStimulus(4, 0, 1'b1);
    checkOutput("sub_R1", 32'(dp_r[1]), 32'd2);
    doReset();

    // run dropped during T1 of the final ALU instruction.
    clearAll();
    mem[0] = enc(1, 3, 0, 16'h00f9);
    mem[1] = enc(1, 4, 0, 16'h0f0f);
    mem[2] = enc(6, 3, 4, 16'h0);
    applyStimulus(3, 1, 1'b0);
    checkOutput("xor_R3", 32'(dp_r[3]), 32'h0ff6);
    doReset();

    // Reset landing in T2 of ADD R2,R2.
    clearAll();
    mem[0] = enc(1, 2, 0, 16'd7);
    mem[1] = enc(2, 2, 2, 16'h0);
    f0 = fetches;
    modelProgram(2);
    run = 1'b1;
    waitFetches(f0 + 2);
    tick();
    tick();
    checkOutput("t2_r_en", 32'(r_en_OH), 32'h200);
    rst_n = 1'b1;
    run   = 1'b0;
    tick();
    rst_n = 1'b0;
    checkOutput("post_rst_r_en", 32'(r_en_OH), 32'd0);
    checkOutput("post_rst_tri", 32'(tri_controller_OH), 32'd0);
    checkOutput("post_rst_code", 32'(code), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_done", 32'(done), 32'd0);
    checkOutput("post_rst_address", 32'(address), 32'd0);
    step_q.delete();
    addr_q.delete();
    repeat (3) tick();
    checkOutput("post_rst_R2", 32'(dp_r[2]), 32'd7);

    // 65 instructions with run held: PC runs 0..63 and wraps to 0.
    clearAll();
    for (int i = 0; i < 64; i++)
      mem[i] = (i < 8) ? enc(1, i, 0, 16'($urandom))
                       : enc(0, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
    applyStimulus(65, 0, 1'b0);
    doReset();

    // Random programs, alternately ending in HALT or in a run drop.
    for (int p = 0; p < 6; p++) begin
      clearAll();
      n = $urandom_range(10, 25);
      randomProgram(n);
      if (p % 2 == 0) applyStimulus(n + 1, 0, 1'b1);
      else            applyStimulus(n, $urandom_range(0, 2), 1'b0);
      doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
